// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path.
//   ps2_state_e      : host-to-device transmit FSM states
//   PS2_FRAME_EDGES  : device clock falling edges per host-to-device frame
//   PS2_CMD_* / RSP_*: common keyboard command / response bytes
//   odd_parity()     : parity bit that makes data+parity carry an odd count of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int         PS2_FRAME_EDGES  = 11;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizer for one raw PS/2 line.
//   i_clk   : system clock
//   i_rst_n : async active-low reset; flops reset to 1 (idle bus level)
//   i_d     : asynchronous line input
//   o_q     : synchronized level
module ps2_host_tx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
//   clk, reset_n          : system clock, async active-low reset
//   tx_valid/tx_data      : command byte offer; accepted when tx_ready is high
//   tx_ready              : idle, accepts a byte this cycle
//   ps2_clk_in/data_in    : raw open-drain line levels
//   ps2_clk_oe/data_oe    : 1 pulls the line low, 0 releases it
//   busy                  : frame in progress
//   done/ack_ok           : one-cycle end-of-frame pulse with device-ack status
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok
);

  localparam int CNT_MAX0 = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > INHIBIT_CYCLES) ? CNT_MAX0 : INHIBIT_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);

  logic w_clk_s, w_data_s, w_fall, w_accept;
  logic r_clk_d;

  ps2_host_tx_sync u_sync_clk  (.i_clk(clk), .i_rst_n(reset_n), .i_d(ps2_clk_in),  .o_q(w_clk_s));
  ps2_host_tx_sync u_sync_data (.i_clk(clk), .i_rst_n(reset_n), .i_d(ps2_data_in), .o_q(w_data_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_clk_d <= 1'b1;
    else          r_clk_d <= w_clk_s;
  end

  assign w_fall = r_clk_d & ~w_clk_s;

  ps2_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [3:0]       r_edges, w_edges_nxt;
  logic [8:0]       r_shift, w_shift_nxt;   // {parity, data}; stop bit shifts in as 1
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_data_oe, w_data_oe_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ack_ok, w_ack_ok_nxt;
  logic             r_ack_pend, w_ack_pend_nxt;

  // done is registered and lands in the first IDLE cycle, so ready is held off there
  assign tx_ready    = reset_n & (r_state == ST_IDLE) & ~r_done;
  assign w_accept    = tx_valid & tx_ready;
  assign busy        = (r_state != ST_IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign ack_ok      = r_ack_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_edges    <= '0;
      r_shift    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_ack_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_edges    <= w_edges_nxt;
      r_shift    <= w_shift_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_ack_ok   <= w_ack_ok_nxt;
      r_ack_pend <= w_ack_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_edges_nxt    = r_edges;
    w_shift_nxt    = r_shift;
    w_clk_oe_nxt   = r_clk_oe;
    w_data_oe_nxt  = r_data_oe;
    w_done_nxt     = 1'b0;
    w_ack_ok_nxt   = r_ack_ok;
    w_ack_pend_nxt = r_ack_pend;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt   = ST_INHIBIT;
          w_shift_nxt   = {odd_parity(tx_data), tx_data};
          w_edges_nxt   = '0;
          w_clk_oe_nxt  = 1'b1;
          w_data_oe_nxt = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
          w_state_nxt   = ST_RTS;
          w_cnt_nxt     = '0;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b1;   // start bit
        end
      end
      ST_RTS: begin
        if (w_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_cnt_nxt     = '0;     // frame timeout runs from the first device edge
          w_edges_nxt   = 4'd1;
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b1, r_shift[8:1]};
        end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_ack_ok_nxt  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          w_edges_nxt = r_edges + 4'd1;
          if (r_edges == 4'(PS2_FRAME_EDGES - 1)) begin
            w_state_nxt = ST_ACK;
          end else begin
            // edges 2..9 put out data[1..7] and parity, edge 10 the shifted-in stop 1
            w_data_oe_nxt = ~r_shift[0];
            w_shift_nxt   = {1'b1, r_shift[8:1]};
          end
        end else if (r_cnt == CW'(FRAME_TIMEOUT - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_ack_ok_nxt  = 1'b0;
        end
      end
      ST_ACK: begin
        w_ack_pend_nxt = ~w_data_s;   // device pulls data low to acknowledge
        w_state_nxt    = ST_WAIT_IDLE;
        w_cnt_nxt      = '0;
      end
      ST_WAIT_IDLE: begin
        if (w_clk_s && w_data_s) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_ack_ok_nxt = r_ack_pend;
        end else if (r_cnt == CW'(FRAME_TIMEOUT - 1)) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_ack_ok_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int STO = 200;
  localparam int FTO = 2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok;
  logic       clk_line, data_line;

  assign clk_line  = dev_clk  & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .FRAME_TIMEOUT(FTO)) dut (
    .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .ack_ok(ack_ok)
  );

  int checks = 0, failures = 0;
  int done_cnt = 0, acc_cnt = 0, inh_run = 0, inh_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame as seen on the wire: [0] start, [8:1] data LSB first, [9] parity, [10] stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2 == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Monitor: done pulses, accepts, length of each clock-inhibit run
  always begin
    @(negedge clk);
    #2;
    if (done) begin
      done_cnt++;
      chk("done_excl_ready", tx_ready, 0);
    end
    if (tx_valid && tx_ready) acc_cnt++;
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
  end

  // Device: waits for request-to-send, clocks 11 edges (50-cycle half period),
  // samples host data before each rising edge, optionally acks on edge 11.
  // rst_edge != 0 asserts reset 10 cycles into the low phase of that edge.
  task automatic dev_run(input bit do_ack, input int rst_edge,
                         output logic [10:0] fr, output bit ok);
    int n;
    ok = 1'b0;
    fr = '0;
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) return;
    ok = 1'b1;
    fr[0] = data_line;
    tick(20);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == rst_edge) begin
        tick(10);
        reset_n = 1'b0;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 0);
        tick(3);
        reset_n  = 1'b1;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        #1;
        chk("rst_release_ready", tx_ready, 1);
        return;
      end
      tick(50);
      if (k <= 10) fr[k] = data_line;
      dev_clk = 1'b1;
      if (k == 10) begin
        tick(25);
        dev_data = ~do_ack;
        tick(25);
      end else if (k == 11) begin
        dev_data = 1'b1;
      end else begin
        tick(50);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit do_ack, input bit hold,
                           input int rst_edge, output logic [10:0] fr,
                           output bit got_done, output bit got_ack);
    int n, d0;
    bit ok;
    got_done = 1'b0;
    got_ack  = 1'b0;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    dev_run(do_ack, rst_edge, fr, ok);
    chk("dev_saw_rts", ok, 1);
    if (rst_edge != 0) return;
    d0 = done_cnt;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    got_done = done;
    got_ack  = ack_ok;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         dev_ack;
    bit         exp_ack;
    bit         exp_par;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [10:0] fr;
    bit          gd, ga;
    int          n, d0, a0;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b1};

    // reset state
    tick(3);
    chk("reset_ready", tx_ready, 0);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ack_ok", ack_ok, 0);
    reset_n = 1'b1;
    #1;
    chk("post_reset_ready", tx_ready, 1);
    tick(2);

    // table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].data, vecs[i].dev_ack, 1'b0, 0, fr, gd, ga);
      chk("tbl_frame", fr, model_frame(vecs[i].data));
      chk("tbl_parity", fr[9], vecs[i].exp_par);
      chk("tbl_done", gd, 1);
      chk("tbl_ack", ga, vecs[i].exp_ack);
      chk("tbl_inhibit_len", inh_last, INH);
      tick(5);
    end

    // randomized frames against the model
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      bit a;
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      run_frame(d, a, 1'b0, 0, fr, gd, ga);
      chk("rnd_frame", fr, model_frame(d));
      chk("rnd_done", gd, 1);
      chk("rnd_ack", ga, a);
      tick(3);
    end

    // device never clocks: start timeout
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!ps2_data_oe && n < 100) begin @(negedge clk); n++; end
    chk("to_rts_seen", ps2_data_oe, 1);
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    chk("to_cycles", n, STO);
    chk("to_ack", ack_ok, 0);
    chk("to_clk_oe", ps2_clk_oe, 0);
    chk("to_data_oe", ps2_data_oe, 0);
    tick(3);

    // reset after edge 5 abandons frame, then 0xFF goes through
    d0 = done_cnt;
    run_frame(8'hA5, 1'b1, 1'b0, 5, fr, gd, ga);
    tick(5);
    chk("rst_no_done", done_cnt - d0, 0);
    run_frame(8'hFF, 1'b1, 1'b0, 0, fr, gd, ga);
    chk("after_rst_frame", fr, model_frame(8'hFF));
    chk("after_rst_ack", ga, 1);
    tick(3);

    // tx_valid held through the whole frame
    a0 = acc_cnt;
    run_frame(8'h55, 1'b1, 1'b1, 0, fr, gd, ga);
    chk("hold_accepts", acc_cnt - a0, 1);
    chk("hold_frame", fr, model_frame(8'h55));
    chk("hold_ack", ga, 1);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
